// File: rtl/wb_pkg.sv
// Shared encodings and defaults for the EX->WB pipeline register and the
// writeback/memory-access stage.
package wb_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        LT_NONE = 3'b000,
        LT_LB   = 3'b001,
        LT_LH   = 3'b010,
        LT_LW   = 3'b011,
        LT_LBU  = 3'b101,
        LT_LHU  = 3'b110
    } load_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE        = 2'b00,
        S_WAIT_GNT    = 2'b01,
        S_WAIT_RVALID = 2'b10
    } wb_state_e;

    // Unlisted load encodings behave as "no load".
    function automatic logic is_load(input logic [2:0] lt);
        logic res;
        case (lt)
            LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load response and extends it to a
// full word according to the load type.
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] load_word
);
    import wb_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by sign/zero extension
    always_comb begin
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (load_type)
            LT_LB:   load_word = {{24{byte_s[7]}}, byte_s};
            LT_LBU:  load_word = {24'h000000, byte_s};
            LT_LH:   load_word = {{16{half_s[15]}}, half_s};
            LT_LHU:  load_word = {16'h0000, half_s};
            default: load_word = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback / memory-access stage: issues data-bus transactions for loads and
// stores, stalls the pipeline while one is outstanding, and writes the register file.
module wb_stage #(
    parameter int WORD_WIDTH = wb_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            load_type_i,
    input  logic [1:0]            store_type_i,
    input  logic                  write_en_i,
    input  logic [WORD_WIDTH-1:0] ex_data_i,
    input  logic [WORD_WIDTH-1:0] store_data_i,
    input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [WORD_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [WORD_WIDTH-1:0] data_wdata_o,
    input  logic [WORD_WIDTH-1:0] data_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [WORD_WIDTH-1:0] rf_wdata_o,
    output logic                  stall_o,
    output logic                  misaligned_o
);
    import wb_pkg::*;

    wb_state_e             state_r, next_state_s;
    logic                  store_op_s, load_op_s, mem_op_s, aligned_s, issue_s;
    logic [1:0]            offset_s;
    logic [3:0]            be_s;
    logic [WORD_WIDTH-1:0] addr_s, wdata_s;

    logic [1:0]            offset_r;
    logic [2:0]            load_type_r;
    logic                  load_we_r, is_store_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [WORD_WIDTH-1:0] addr_r, wdata_r;
    logic [3:0]            be_r;

    logic                  rf_we_s, rf_we_r, misaligned_s, misaligned_r;
    logic [ADDR_WIDTH-1:0] rf_waddr_s, rf_waddr_r;
    logic [WORD_WIDTH-1:0] rf_wdata_s, rf_wdata_r;
    logic [WORD_WIDTH-1:0] load_word_s;

    // Decode the incoming op: precedence, alignment, byte lanes and store data
    always_comb begin
        store_op_s = (store_type_i != ST_NONE);
        load_op_s  = is_load(load_type_i) && !store_op_s;
        mem_op_s   = store_op_s || load_op_s;
        offset_s   = ex_data_i[1:0];
        addr_s     = {ex_data_i[WORD_WIDTH-1:2], 2'b00};
        be_s       = 4'b1111;
        wdata_s    = store_data_i;
        aligned_s  = 1'b1;
        if (store_op_s) begin
            case (store_type_i)
                ST_SB: begin
                    be_s    = 4'b0001 << offset_s;
                    wdata_s = {4{store_data_i[7:0]}};
                end
                ST_SH: begin
                    be_s      = offset_s[1] ? 4'b1100 : 4'b0011;
                    wdata_s   = {2{store_data_i[15:0]}};
                    aligned_s = ~offset_s[0];
                end
                ST_SW:   aligned_s = (offset_s == 2'b00);
                default: aligned_s = 1'b1;
            endcase
        end else begin
            case (load_type_i)
                LT_LH, LT_LHU: aligned_s = ~offset_s[0];
                LT_LW:         aligned_s = (offset_s == 2'b00);
                default:       aligned_s = 1'b1;
            endcase
        end
        issue_s = (state_r == S_IDLE) && mem_op_s && aligned_s;
    end

    load_align u_load_align (
        .rdata     (data_rdata_i),
        .offset    (offset_r),
        .load_type (load_type_r),
        .load_word (load_word_s)
    );

    // Next state, bus/stall outputs and the next register-file write
    always_comb begin
        next_state_s = state_r;
        data_req_o   = 1'b0;
        stall_o      = 1'b0;
        data_addr_o  = addr_r;
        data_we_o    = is_store_r;
        data_be_o    = be_r;
        data_wdata_o = wdata_r;
        rf_we_s      = 1'b0;
        rf_waddr_s   = rf_waddr_r;
        rf_wdata_s   = rf_wdata_r;
        misaligned_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                data_addr_o  = addr_s;
                data_we_o    = store_op_s;
                data_be_o    = be_s;
                data_wdata_o = wdata_s;
                if (issue_s) begin
                    data_req_o   = 1'b1;
                    stall_o      = 1'b1;
                    next_state_s = data_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                end else if (mem_op_s) begin
                    misaligned_s = 1'b1;
                end else begin
                    rf_we_s    = write_en_i;
                    rf_waddr_s = reg_waddr_i;
                    rf_wdata_s = ex_data_i;
                end
            end
            S_WAIT_GNT: begin
                data_req_o = 1'b1;
                stall_o    = 1'b1;
                if (data_gnt_i) begin
                    next_state_s = S_WAIT_RVALID;
                end else begin
                    next_state_s = S_WAIT_GNT;
                end
            end
            S_WAIT_RVALID: begin
                // Stall drops in the rvalid cycle so the EX->WB register advances
                if (data_rvalid_i) begin
                    next_state_s = S_IDLE;
                    rf_we_s      = !is_store_r && load_we_r;
                    rf_waddr_s   = waddr_r;
                    rf_wdata_s   = load_word_s;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register and capture of the transaction at issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            offset_r    <= 2'b00;
            load_type_r <= 3'b000;
            load_we_r   <= 1'b0;
            is_store_r  <= 1'b0;
            waddr_r     <= '0;
            addr_r      <= '0;
            be_r        <= 4'b0000;
            wdata_r     <= '0;
        end else begin
            state_r <= next_state_s;
            if (issue_s) begin
                offset_r    <= offset_s;
                load_type_r <= load_type_i;
                load_we_r   <= write_en_i;
                is_store_r  <= store_op_s;
                waddr_r     <= reg_waddr_i;
                addr_r      <= addr_s;
                be_r        <= be_s;
                wdata_r     <= wdata_s;
            end
        end
    end

    // Registered register-file write and misalignment pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r      <= 1'b0;
            rf_waddr_r   <= '0;
            rf_wdata_r   <= '0;
            misaligned_r <= 1'b0;
        end else begin
            rf_we_r      <= rf_we_s;
            rf_waddr_r   <= rf_waddr_s;
            rf_wdata_r   <= rf_wdata_s;
            misaligned_r <= misaligned_s;
        end
    end

    assign rf_we_o      = rf_we_r;
    assign rf_waddr_o   = rf_waddr_r;
    assign rf_wdata_o   = rf_wdata_r;
    assign misaligned_o = misaligned_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, randomized ops
// against a transaction-level model, and an asynchronous reset mid-load.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic        write_en_i;
    logic [31:0] ex_data_i, store_data_i;
    logic [4:0]  reg_waddr_i;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        rf_we_o, stall_o, misaligned_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int n_checks;
    int n_fail;

    wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_type_i   (load_type_i),
        .store_type_i  (store_type_i),
        .write_en_i    (write_en_i),
        .ex_data_i     (ex_data_i),
        .store_data_i  (store_data_i),
        .reg_waddr_i   (reg_waddr_i),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .stall_o       (stall_o),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  lt;
        logic [1:0]  st;
        logic        we;
        logic [31:0] ex;
        logic [31:0] sd;
        logic [4:0]  rd;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic        spur;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rfwe;
        logic [31:0] e_rfwdata;
        logic        e_mis;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        load_type_i  = 3'd0;
        store_type_i = 2'd0;
        write_en_i   = 1'b0;
        ex_data_i    = 32'h0;
        store_data_i = 32'h0;
        reg_waddr_i  = 5'd0;
    endtask

    function automatic vec_t mk(input logic [2:0] lt, input logic [1:0] st, input logic we,
                                input logic [31:0] ex, input logic [31:0] sd, input logic [4:0] rd,
                                input int gd, input int rvd, input logic [31:0] rdata,
                                input logic e_req, input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic e_rfwe, input logic [31:0] e_rfwdata, input logic e_mis);
        vec_t v;
        v.lt = lt; v.st = st; v.we = we; v.ex = ex; v.sd = sd; v.rd = rd;
        v.gnt_dly = gd; v.rv_dly = rvd; v.rdata = rdata; v.spur = 1'b0;
        v.e_req = e_req; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_rfwe = e_rfwe; v.e_rfwdata = e_rfwdata; v.e_mis = e_mis;
        return v;
    endfunction

    // Reference model: access size and alignment by arithmetic, lanes by shifting
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          size, off;
        bit          is_st, is_ld, sgn;
        logic [31:0] mask, val;
        r     = v;
        off   = int'(v.ex & 32'd3);
        is_st = (v.st != 2'd0);
        is_ld = !is_st && (v.lt inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6});
        size  = 0;
        sgn   = 1'b0;
        if (is_st) size = (v.st == 2'd1) ? 1 : (v.st == 2'd2) ? 2 : 4;
        else if (is_ld) begin
            size = (v.lt == 3'd1 || v.lt == 3'd5) ? 1 : (v.lt == 3'd3) ? 4 : 2;
            sgn  = (v.lt == 3'd1 || v.lt == 3'd2);
        end
        r.e_mis = (size != 0) && ((off % size) != 0);
        r.e_req = (size != 0) && !r.e_mis;
        r.e_be  = is_st ? 4'(((1 << size) - 1) << off) : 4'b0000;
        if (size == 1)      r.e_wdata = {24'h0, v.sd[7:0]} * 32'h01010101;
        else if (size == 2) r.e_wdata = {16'h0, v.sd[15:0]} * 32'h00010001;
        else                r.e_wdata = v.sd;
        val = v.rdata >> (8 * off);
        if (size > 0 && size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            val  = val & mask;
            if (sgn && val > (mask >> 1)) val = val | ~mask;
        end
        r.e_rfwe    = v.we && ((size == 0) || (r.e_req && is_ld));
        r.e_rfwdata = (size == 0) ? v.ex : val;
        return r;
    endfunction

    // Drives one op at posedge+1 and acts as the bus; returns at posedge+1 after
    // the result cycle so the next op is presented back-to-back.
    task automatic run_op(input vec_t v);
        logic [31:0] e_addr;
        logic        is_st;
        e_addr       = {v.ex[31:2], 2'b00};
        is_st        = (v.st != 2'd0);
        load_type_i  = v.lt;
        store_type_i = v.st;
        write_en_i   = v.we;
        ex_data_i    = v.ex;
        store_data_i = v.sd;
        reg_waddr_i  = v.rd;
        data_gnt_i    = v.e_req && (v.gnt_dly == 0);
        data_rvalid_i = v.spur;
        data_rdata_i  = $urandom;
        #1;
        chk("req_issue", 32'(data_req_o), 32'(v.e_req));
        chk("stall_issue", 32'(stall_o), 32'(v.e_req));
        if (v.e_req) begin
            chk("addr", data_addr_o, e_addr);
            chk("we", 32'(data_we_o), 32'(is_st));
            if (is_st) begin
                chk("be", 32'(data_be_o), 32'(v.e_be));
                chk("wdata", data_wdata_o, v.e_wdata);
            end
            for (int k = 1; k <= v.gnt_dly; k++) begin
                step();
                data_gnt_i    = (k == v.gnt_dly);
                data_rvalid_i = v.spur;
                data_rdata_i  = $urandom;
                #1;
                chk("req_wait_gnt", 32'(data_req_o), 32'd1);
                chk("stall_wait_gnt", 32'(stall_o), 32'd1);
                chk("addr_hold", data_addr_o, e_addr);
                chk("we_hold", 32'(data_we_o), 32'(is_st));
                if (is_st) begin
                    chk("be_hold", 32'(data_be_o), 32'(v.e_be));
                    chk("wdata_hold", data_wdata_o, v.e_wdata);
                end
            end
            for (int j = 1; j <= v.rv_dly; j++) begin
                step();
                data_gnt_i    = 1'b0;
                data_rvalid_i = (j == v.rv_dly);
                data_rdata_i  = (j == v.rv_dly) ? v.rdata : $urandom;
                #1;
                chk("req_wait_rvalid", 32'(data_req_o), 32'd0);
                chk("stall_wait_rvalid", 32'(stall_o), 32'(j != v.rv_dly));
                chk("rf_we_pending", 32'(rf_we_o), 32'd0);
                chk("mis_pending", 32'(misaligned_o), 32'd0);
            end
        end
        step();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        chk("rf_we", 32'(rf_we_o), 32'(v.e_rfwe));
        if (v.e_rfwe) begin
            chk("rf_waddr", 32'(rf_waddr_o), 32'(v.rd));
            chk("rf_wdata", rf_wdata_o, v.e_rfwdata);
        end
        chk("misaligned", 32'(misaligned_o), 32'(v.e_mis));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //           lt    st    we    ex          sd            rd    gd rv rdata          req   be       wdata          rfwe  rfwdata        mis
        tbl[0]  = mk(3'd0, 2'd0, 1'b1, 32'h1234,   32'h0,        5'd5, 0, 1, 32'h0,         1'b0, 4'h0,    32'h0,         1'b1, 32'h00001234, 1'b0);
        tbl[1]  = mk(3'd1, 2'd0, 1'b1, 32'h103,    32'h0,        5'd8, 0, 2, 32'h80AABBCC,  1'b1, 4'h0,    32'h0,         1'b1, 32'hFFFFFF80, 1'b0);
        tbl[2]  = mk(3'd0, 2'd2, 1'b1, 32'h202,    32'h0000BEEF, 5'd7, 3, 1, 32'h0,         1'b1, 4'b1100, 32'hBEEFBEEF,  1'b0, 32'h0,        1'b0);
        tbl[3]  = mk(3'd3, 2'd0, 1'b1, 32'h201,    32'h0,        5'd4, 0, 1, 32'h0,         1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b1);
        tbl[4]  = mk(3'd6, 2'd0, 1'b1, 32'h2,      32'h0,        5'd9, 0, 1, 32'h80011234,  1'b1, 4'h0,    32'h0,         1'b1, 32'h00008001, 1'b0);
        tbl[5]  = mk(3'd0, 2'd1, 1'b0, 32'h5,      32'h12345678, 5'd0, 0, 1, 32'h0,         1'b1, 4'b0010, 32'h78787878,  1'b0, 32'h0,        1'b0);
        tbl[6]  = mk(3'd2, 2'd0, 1'b1, 32'h6,      32'h0,        5'd10,1, 3, 32'h9ABC0000,  1'b1, 4'h0,    32'h0,         1'b1, 32'hFFFF9ABC, 1'b0);
        tbl[7]  = mk(3'd5, 2'd0, 1'b1, 32'h1,      32'h0,        5'd11,2, 1, 32'h0000F100,  1'b1, 4'h0,    32'h0,         1'b1, 32'h000000F1, 1'b0);
        tbl[8]  = mk(3'd0, 2'd3, 1'b0, 32'h10,     32'hDEADBEEF, 5'd0, 0, 2, 32'h0,         1'b1, 4'b1111, 32'hDEADBEEF,  1'b0, 32'h0,        1'b0);
        tbl[9]  = mk(3'd3, 2'd1, 1'b1, 32'h3,      32'h000000A5, 5'd12,1, 1, 32'h0,         1'b1, 4'b1000, 32'hA5A5A5A5,  1'b0, 32'h0,        1'b0);
        tbl[10] = mk(3'd0, 2'd2, 1'b0, 32'h1,      32'h0000FFFF, 5'd0, 0, 1, 32'h0,         1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b1);
        tbl[11] = mk(3'd3, 2'd0, 1'b0, 32'h8,      32'h0,        5'd13,0, 1, 32'h12345678,  1'b1, 4'h0,    32'h0,         1'b0, 32'h0,        1'b0);
        tbl[12] = mk(3'd4, 2'd0, 1'b1, 32'h55,     32'h0,        5'd14,0, 1, 32'h0,         1'b0, 4'h0,    32'h0,         1'b1, 32'h00000055, 1'b0);
        tbl[13] = mk(3'd3, 2'd0, 1'b1, 32'h20,     32'h0,        5'd0, 0, 1, 32'hCAFEF00D,  1'b1, 4'h0,    32'h0,         1'b1, 32'hCAFEF00D, 1'b0);
        tbl[14] = mk(3'd0, 2'd0, 1'b0, 32'h77,     32'h0,        5'd2, 0, 1, 32'h0,         1'b0, 4'h0,    32'h0,         1'b0, 32'h0,        1'b0);

        rst_n         = 1'b0;
        set_idle();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(rf_we_o), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("reset_rf_wdata", rf_wdata_o, 32'd0);
        chk("reset_mis", 32'(misaligned_o), 32'd0);
        chk("reset_req", 32'(data_req_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i]);
        end

        for (int i = 0; i < 200; i++) begin
            vec_t v;
            v.lt      = 3'($urandom_range(0, 7));
            v.st      = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.we      = 1'($urandom);
            v.ex      = $urandom;
            v.sd      = $urandom;
            v.rd      = 5'($urandom);
            v.gnt_dly = int'($urandom_range(0, 3));
            v.rv_dly  = int'($urandom_range(1, 3));
            v.rdata   = $urandom;
            v.spur    = ($urandom_range(0, 3) == 0);
            run_op(model(v));
        end

        // Asynchronous reset while a load waits for rvalid; the late rvalid is ignored
        run_op(mk(3'd0, 2'd0, 1'b1, 32'hABCD, 32'h0, 5'd3, 0, 1, 32'h0,
                  1'b0, 4'h0, 32'h0, 1'b1, 32'h0000ABCD, 1'b0));
        load_type_i  = 3'd3;
        store_type_i = 2'd0;
        write_en_i   = 1'b1;
        ex_data_i    = 32'h40;
        reg_waddr_i  = 5'd6;
        data_gnt_i   = 1'b1;
        #1;
        chk("rst_seq_req", 32'(data_req_o), 32'd1);
        step();
        data_gnt_i = 1'b0;
        #1;
        chk("rst_seq_stall", 32'(stall_o), 32'd1);
        chk("rst_seq_rf_wdata_held", rf_wdata_o, 32'h0000ABCD);
        rst_n = 1'b0;
        set_idle();
        #1;
        chk("rst_seq_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_seq_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_seq_rf_wdata", rf_wdata_o, 32'd0);
        chk("rst_seq_mis", 32'(misaligned_o), 32'd0);
        chk("rst_seq_req_idle", 32'(data_req_o), 32'd0);
        chk("rst_seq_stall_idle", 32'(stall_o), 32'd0);
        step();
        rst_n         = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h11111111;
        #1;
        chk("late_rvalid_stall", 32'(stall_o), 32'd0);
        chk("late_rvalid_req", 32'(data_req_o), 32'd0);
        step();
        data_rvalid_i = 1'b0;
        #1;
        chk("late_rvalid_rf_we", 32'(rf_we_o), 32'd0);
        chk("late_rvalid_rf_wdata", rf_wdata_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
